// File: rtl/alu8bit_arbiter.sv
// alu8bit_arbiter: round-robin sharing of one ALU8bit between NREQ requesters with a tagged response channel
module alu8bit_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [3*NREQ-1:0]   req_opcode,
  input  logic [8*NREQ-1:0]   req_op1,
  input  logic [8*NREQ-1:0]   req_op2,
  output logic [2:0]          alu_opcode,
  output logic [7:0]          alu_operand1,
  output logic [7:0]          alu_operand2,
  input  logic [15:0]         alu_result,
  input  logic                alu_flagC,
  input  logic                alu_flagZ,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic [15:0]         rsp_result,
  output logic                rsp_flagC,
  output logic                rsp_flagZ
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t         r_state, w_next;
  logic [IDW-1:0] r_ptr, r_id, w_off, w_win;
  logic [IDW:0]   w_sum;
  logic [NREQ-1:0] w_rot;
  logic           w_any;
  logic [2:0]     r_opcode;
  logic [7:0]     r_op1, r_op2;
  logic           r_valid, r_c, r_z;
  logic [15:0]    r_result;
  // rotate so bit 0 is the requester at ptr; the lowest set bit is the winner's offset
  always_comb begin
    w_rot = NREQ'({req_valid, req_valid} >> r_ptr);
    w_any = |req_valid;
    w_off = '0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (w_rot[k]) w_off = IDW'(k);
    w_sum = {1'b0, r_ptr} + {1'b0, w_off};
    w_win = (w_sum >= (IDW+1)'(NREQ)) ? IDW'(w_sum - (IDW+1)'(NREQ)) : w_sum[IDW-1:0];
  end
  assign req_ready = (r_state == IDLE && w_any && !rst) ? NREQ'(1) << w_win : '0;
  always_comb
    w_next = (r_state == IDLE) ? (w_any ? EXEC : IDLE) :
             (r_state == EXEC) ? RESP : (rsp_ready ? IDLE : RESP);
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_ptr    <= '0;
      r_id     <= '0;
      r_opcode <= '0;
      r_op1    <= '0;
      r_op2    <= '0;
      r_valid  <= 1'b0;
      r_result <= '0;
      r_c      <= 1'b0;
      r_z      <= 1'b0;
    end else if (r_state == IDLE && w_any) begin
      r_opcode <= 3'(req_opcode >> (3 * w_win));
      r_op1    <= 8'(req_op1 >> (8 * w_win));
      r_op2    <= 8'(req_op2 >> (8 * w_win));
      r_id     <= w_win;
    end else if (r_state == EXEC) begin
      r_result <= alu_result;
      r_c      <= alu_flagC;
      r_z      <= alu_flagZ;
      r_valid  <= 1'b1;
    end else if (r_state == RESP && rsp_ready) begin
      r_valid <= 1'b0;
      r_ptr   <= (r_id == IDW'(NREQ - 1)) ? '0 : r_id + 1'b1;
    end
  assign alu_opcode   = r_opcode;
  assign alu_operand1 = r_op1;
  assign alu_operand2 = r_op2;
  assign rsp_valid    = r_valid;
  assign rsp_id       = r_id;
  assign rsp_result   = r_result;
  assign rsp_flagC    = r_c;
  assign rsp_flagZ    = r_z;
endmodule

// File: tb/tb_alu8bit_arbiter.sv
// tb_alu8bit_arbiter: directed scoreboard bench for alu8bit_arbiter with a small stand-in ALU8bit
module tb_alu8bit_arbiter;
  localparam int N = 4;
  logic         clk = 1'b0, rst = 1'b1;
  logic [N-1:0] req_valid = '0, req_ready;
  logic [3*N-1:0] req_opcode = '0;
  logic [8*N-1:0] req_op1 = '0, req_op2 = '0;
  logic [2:0]   alu_opcode;
  logic [7:0]   alu_operand1, alu_operand2;
  logic [15:0]  alu_result, rsp_result;
  logic         alu_flagC, alu_flagZ, rsp_valid, rsp_ready = 1'b1, rsp_flagC, rsp_flagZ;
  logic [1:0]   rsp_id;
  logic [19:0]  q[$];
  int           n_cmp = 0, n_err = 0, cyc = 0;
  logic [15:0]  sw_res [8] = '{16'h00FF, 16'h0055, 16'h0000, 16'h00FF, 16'h00FF, 16'h3872, 16'h0154, 16'h0055};
  logic [7:0]   sw_c = 8'b0110_0000, sw_z = 8'b0000_0100;
  alu8bit_arbiter #(.NREQ(N), .IDW(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_op1(req_op1), .req_op2(req_op2),
    .alu_opcode(alu_opcode), .alu_operand1(alu_operand1), .alu_operand2(alu_operand2),
    .alu_result(alu_result), .alu_flagC(alu_flagC), .alu_flagZ(alu_flagZ),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_flagC(rsp_flagC), .rsp_flagZ(rsp_flagZ)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // stand-in ALU8bit: add, sub, and, or, xor, mul, shl, not
  always_comb begin
    alu_result = 16'h0000;
    case (alu_opcode)
      3'd0: alu_result = {8'h00, alu_operand1} + {8'h00, alu_operand2};
      3'd1: alu_result = {8'h00, alu_operand1} - {8'h00, alu_operand2};
      3'd2: alu_result = {8'h00, alu_operand1 & alu_operand2};
      3'd3: alu_result = {8'h00, alu_operand1 | alu_operand2};
      3'd4: alu_result = {8'h00, alu_operand1 ^ alu_operand2};
      3'd5: alu_result = {8'h00, alu_operand1} * {8'h00, alu_operand2};
      3'd6: alu_result = {7'h00, alu_operand1, 1'b0};
      default: alu_result = {8'h00, ~alu_operand1};
    endcase
    alu_flagC = |alu_result[15:8];
    alu_flagZ = (alu_result == 16'h0000);
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
    end
  endtask
  task automatic push(input logic [1:0] id, input logic [15:0] r, input logic c, input logic z);
    q.push_back({id, r, c, z});
  endtask
  task automatic set_req(input int id, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    req_opcode[3*id +: 3] = op;
    req_op1[8*id +: 8] = a;
    req_op2[8*id +: 8] = b;
  endtask
  task automatic grant_wait(input int id, output int c);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_ready != '0) break;
    end
    chk("grant", 32'(req_ready), 32'(1) << id);
    chk("onehot", 32'($onehot0(req_ready)), 32'd1);
    c = cyc;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk)
    if (!rst && rsp_valid && rsp_ready) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_rsp: got id %0d result %h with no response expected", rsp_id, rsp_result);
      end else
        chk("rsp", 32'({rsp_id, rsp_result, rsp_flagC, rsp_flagZ}), 32'(q.pop_front()));
    end
  initial begin
    int c, c0, prev;
    int order [6] = '{0, 1, 2, 3, 0, 1};
    req_valid = 4'b1111;
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_outs", {alu_opcode, alu_operand1, alu_operand2, rsp_valid, rsp_id, rsp_flagC, rsp_flagZ}, 32'd0);
    chk("rst_result", 32'(rsp_result), 32'd0);
    step();
    step();
    rst = 1'b0;
    req_valid = '0;
    // single requester and latency
    set_req(2, 3'd0, 8'hAA, 8'h55);
    push(2'd2, 16'h00FF, 1'b0, 1'b0);
    req_valid = 4'b0100;
    grant_wait(2, c);
    step();
    req_valid = '0;
    @(negedge clk);
    chk("exec_alu_in", {alu_opcode, alu_operand1, alu_operand2}, {3'd0, 8'hAA, 8'h55});
    chk("exec_quiet", {req_ready, rsp_valid}, 32'd0);
    @(negedge clk);
    chk("resp_valid", 32'(rsp_valid), 32'd1);
    step();
    // opcode sweep, one operation every 3 cycles
    set_req(0, 3'd0, 8'hAA, 8'h55);
    req_valid = 4'b0001;
    prev = 0;
    for (int op = 0; op < 8; op++) begin
      req_opcode[2:0] = 3'(op);
      push(2'd0, sw_res[op], sw_c[op], sw_z[op]);
      grant_wait(0, c);
      if (op > 0) chk("sweep_gap", c - prev, 3);
      prev = c;
      step();
    end
    req_valid = '0;
    step();
    step();
    // fairness from reset
    rst = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 3'd0, 8'(i + 1), 8'h10);
    req_valid = 4'b1111;
    step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) push(2'(order[i]), 16'h0011 + 16'(order[i]), 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) grant_wait(order[i], c);
    step();
    req_valid = '0;
    // pointer wrap after a grant to 3
    set_req(3, 3'd2, 8'hFF, 8'h0F);
    req_valid = 4'b1000;
    push(2'd3, 16'h000F, 1'b0, 1'b0);
    grant_wait(3, c);
    step();
    set_req(0, 3'd0, 8'hAA, 8'h55);
    set_req(2, 3'd3, 8'h12, 8'h21);
    req_valid = 4'b0101;
    push(2'd0, 16'h00FF, 1'b0, 1'b0);
    push(2'd2, 16'h0033, 1'b0, 1'b0);
    grant_wait(0, c);
    step();
    req_valid = 4'b0100;
    grant_wait(2, c);
    step();
    req_valid = '0;
    step();
    step();
    // backpressure holds the response and blocks grants
    rsp_ready = 1'b0;
    set_req(1, 3'd5, 8'h10, 8'h10);
    req_valid = 4'b0010;
    push(2'd1, 16'h0100, 1'b1, 1'b0);
    grant_wait(1, c);
    step();
    set_req(0, 3'd6, 8'h80, 8'h00);
    req_valid = 4'b0001;
    step();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp", 32'({rsp_id, rsp_result, rsp_flagC, rsp_flagZ}), 32'({2'd1, 16'h0100, 1'b1, 1'b0}));
      chk("bp_ready", 32'(req_ready), 32'd0);
    end
    step();
    rsp_ready = 1'b1;
    c0 = cyc;
    push(2'd0, 16'h0100, 1'b1, 1'b0);
    grant_wait(0, c);
    chk("bp_regrant", c - c0, 1);
    step();
    req_valid = '0;
    step();
    step();
    // reset during EXEC discards the operation
    set_req(3, 3'd1, 8'h10, 8'h01);
    req_valid = 4'b1000;
    grant_wait(3, c);
    step();
    rst = 1'b1;
    req_valid = '0;
    #1;
    chk("mid_rst_outs", {alu_opcode, alu_operand1, alu_operand2, rsp_valid, rsp_id, rsp_flagC, rsp_flagZ}, 32'd0);
    chk("mid_rst_result", {req_ready, rsp_result}, 32'd0);
    step();
    rst = 1'b0;
    set_req(0, 3'd2, 8'h0F, 8'hF0);
    set_req(3, 3'd4, 8'h3C, 8'hC3);
    req_valid = 4'b1001;
    push(2'd0, 16'h0000, 1'b0, 1'b1);
    push(2'd3, 16'h00FF, 1'b0, 1'b0);
    grant_wait(0, c);
    step();
    req_valid = 4'b1000;
    grant_wait(3, c);
    step();
    req_valid = '0;
    for (int k = 0; k < 30; k++) begin
      if (q.size() == 0) break;
      @(negedge clk);
    end
    chk("drain", q.size(), 0);
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/alu8bit_arbiter.md
# alu8bit_arbiter

Round-robin scheduler that shares one ALU8bit datapath between NREQ independent requesters. Each requester posts an opcode/operand pair with a valid/ready handshake. The block grants one requester at a time, drives the ALU inputs from registers, and captures the ALU result and flags. It then returns them on a single response channel tagged with the requester ID. It sits between the client blocks and the combinational ALU8bit instance, which is instantiated alongside it at the same level.

## Interface
- NREQ, 4, number of requesters (2..8)
- IDW, 2, width of requester ID; must satisfy 2^IDW >= NREQ
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  bit i: requester i has a pending operation
- req_ready  out  NREQ  bit i: requester i's operation is accepted this cycle (one-hot or zero)
- req_opcode  in  3*NREQ  opcode of requester i in bits [3i+2:3i]
- req_op1  in  8*NREQ  Operand1 of requester i in bits [8i+7:8i]
- req_op2  in  8*NREQ  Operand2 of requester i in bits [8i+7:8i]
- alu_opcode  out  3  to ALU8bit Opcode (registered)
- alu_operand1  out  8  to ALU8bit Operand1 (registered)
- alu_operand2  out  8  to ALU8bit Operand2 (registered)
- alu_result  in  16  from ALU8bit Result
- alu_flagC  in  1  from ALU8bit flagC
- alu_flagZ  in  1  from ALU8bit flagZ
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts the response
- rsp_id  out  IDW  index of the requester that owns the response
- rsp_result  out  16  captured ALU Result
- rsp_flagC  out  1  captured flagC
- rsp_flagZ  out  1  captured flagZ

## Operation
- FSM states: IDLE, EXEC, RESP. All state and outputs are registered except req_ready.
- IDLE: if any req_valid bit is set, the winner is the first set bit searching upward from ptr, wrapping at NREQ-1 to 0.
  - req_ready[winner] is high combinationally in this cycle. All other ready bits are low.
  - On the clock edge, the block latches the winner's opcode/op1/op2 into alu_*, latches the winner into rsp_id, and moves to EXEC.
  - If no bit is set, it stays in IDLE. req_ready is all zero and alu_* hold their previous values.
- EXEC: the ALU settles on the registered inputs. On the edge, the block captures alu_result/alu_flagC/alu_flagZ into rsp_*, sets rsp_valid, and moves to RESP.
- RESP: rsp_valid=1 and rsp_* are held stable. When rsp_ready=1 on an edge:
  - rsp_valid clears.
  - ptr becomes (rsp_id+1) mod NREQ.
  - The FSM returns to IDLE.
- req_ready is zero in EXEC and RESP regardless of req_valid.
- Opcodes are passed through uninterpreted. All 8 values are legal.
- A requester may drop req_valid at any time before it is granted; it is never granted while its valid is low.
- ptr wraps modulo NREQ. A requester that wins is lowest priority for the next arbitration, so no requester waits more than NREQ-1 grants.

## Timing
- Reset (asynchronous assert, synchronous release):
  - state = IDLE, ptr = 0, rsp_valid = 0, rsp_id = 0, rsp_result = 16'h0000, rsp_flagC = 0, rsp_flagZ = 0.
  - alu_opcode = 0, alu_operand1 = 8'h00, alu_operand2 = 8'h00.
  - req_ready = 0 while rst is high.
- Latency: grant in cycle T, alu_* valid from T+1, rsp_valid high from T+2.
- Maximum throughput is one operation per 3 cycles, when rsp_ready is held high.
- Backpressure: with rsp_ready low, the FSM stays in RESP indefinitely, rsp_* are unchanged, and no new grant is issued.
- rsp_ready high while rsp_valid is low has no effect.
- Reset mid-operation (in EXEC or RESP): the in-flight operation is discarded with no response and the block returns to reset values. A requester must re-present any request that was granted but not responded to.
- Simultaneous requests in IDLE: exactly one grant, chosen by ptr order.

## Test plan
- Single requester: rst, then req_valid=4'b0100, opcode 3'd0, op1 8'hAA, op2 8'h55 -> req_ready=4'b0100 for one cycle. Two cycles later rsp_valid=1, rsp_id=2, and rsp_result/flags equal the ALU8bit output for (0, AA, 55).
- Opcode sweep: requester 0 issues opcodes 0..7 with AA/55, rsp_ready held high -> 8 responses, one every 3 cycles. Each response matches the ALU8bit reference model.
- Fairness: all four req_valid held high from reset -> grant order 0,1,2,3,0,1. No ready pulse overlaps another.
- Pointer wrap: after a grant to 3, requesters 0 and 2 are valid -> requester 0 is granted first, then 2.
- Backpressure: rsp_ready low for 5 cycles in RESP -> rsp_* stable and req_ready=0 throughout. The next grant occurs the cycle after rsp_ready rises.
- Reset mid-EXEC: assert rst for 1 cycle during EXEC -> no rsp_valid pulse, and all outputs return to their reset values immediately. The next request is granted starting from ptr=0.
